// File: rtl/msk_unmask_serial.sv
// Serial unmasking of d-share Boolean sharings: one share folded into the accumulator per cycle.
// Optional MSK_UNMASK_ZEROIZE_EN clears each share slot in the share register once it has been absorbed.
module msk_unmask_serial #(
    parameter int d     = 2,
    parameter int count = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [count*d-1:0]   in_shares,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [count-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int IW = $clog2(d) + 1;
    localparam logic [IW-1:0] LAST = IW'(d - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t                 state, state_next;
    logic [count*d-1:0]     share_reg, share_next;
    logic [count-1:0]       acc, acc_next;
    logic [IW-1:0]          idx, idx_next;
    logic [count-1:0]       sel_share;

    // Pick share[idx] of every bit; only one raw share per bit ever meets the accumulator.
    always_comb begin
        sel_share = '0;
        for (int i = 0; i < count; i++) begin
            for (int j = 0; j < d; j++) begin
                if (idx == IW'(j)) begin
                    sel_share[i] = share_reg[i*d+j];
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        share_next = share_reg;
        acc_next   = acc;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    share_next = in_shares;
                    for (int i = 0; i < count; i++) begin
                        acc_next[i] = in_shares[i*d];
`ifdef MSK_UNMASK_ZEROIZE_EN
                        share_next[i*d] = 1'b0;
`endif
                    end
                    idx_next   = IW'(1);
                    state_next = (d > 1) ? ACC : DONE;
                end
            end
            ACC: begin
                acc_next = acc ^ sel_share;
`ifdef MSK_UNMASK_ZEROIZE_EN
                for (int i = 0; i < count; i++) begin
                    for (int j = 0; j < d; j++) begin
                        if (idx == IW'(j)) begin
                            share_next[i*d+j] = 1'b0;
                        end
                    end
                end
`endif
                idx_next = idx + IW'(1);
                if (idx == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            share_reg <= '0;
            acc       <= '0;
            idx       <= '0;
        end else begin
            state     <= state_next;
            share_reg <= share_next;
            acc       <= acc_next;
            idx       <= idx_next;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = (state == DONE) ? acc : '0;

endmodule

// File: tb/tb_msk_unmask_serial.sv
// Directed bench for msk_unmask_serial across several d/count configurations.
// Share-register expectations follow MSK_UNMASK_ZEROIZE_EN when it is defined for the build.
module tb_msk_unmask_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // d=2, count=1
    logic [1:0]  shares_a;
    logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1;
    logic [0:0]  out_data_a;
    // d=3, count=4
    logic [11:0] shares_b;
    logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
    logic [3:0]  out_data_b;
    // d=2, count=2
    logic [3:0]  shares_c;
    logic        in_valid_c = 1'b0, in_ready_c, out_valid_c, out_ready_c = 1'b1;
    logic [1:0]  out_data_c;
    // d=4, count=1
    logic [3:0]  shares_e;
    logic        in_valid_e = 1'b0, in_ready_e, out_valid_e, out_ready_e = 1'b1;
    logic [0:0]  out_data_e;
    // d=1, count=8
    logic [7:0]  shares_f;
    logic        in_valid_f = 1'b0, in_ready_f, out_valid_f, out_ready_f = 1'b1;
    logic [7:0]  out_data_f;
    // d=3, count=2
    logic [5:0]  shares_g;
    logic        in_valid_g = 1'b0, in_ready_g, out_valid_g, out_ready_g = 1'b1;
    logic [1:0]  out_data_g;

`ifdef MSK_UNMASK_ZEROIZE_EN
    localparam logic [5:0] EXP_SHARE_REG_G = 6'h00;
`else
    localparam logic [5:0] EXP_SHARE_REG_G = 6'h3D;
`endif

    msk_unmask_serial #(.d(2), .count(1)) u_a (
        .clk(clk), .rst(rst), .in_shares(shares_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a));
    msk_unmask_serial #(.d(3), .count(4)) u_b (
        .clk(clk), .rst(rst), .in_shares(shares_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b));
    msk_unmask_serial #(.d(2), .count(2)) u_c (
        .clk(clk), .rst(rst), .in_shares(shares_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .out_data(out_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c));
    msk_unmask_serial #(.d(4), .count(1)) u_e (
        .clk(clk), .rst(rst), .in_shares(shares_e), .in_valid(in_valid_e), .in_ready(in_ready_e),
        .out_data(out_data_e), .out_valid(out_valid_e), .out_ready(out_ready_e));
    msk_unmask_serial #(.d(1), .count(8)) u_f (
        .clk(clk), .rst(rst), .in_shares(shares_f), .in_valid(in_valid_f), .in_ready(in_ready_f),
        .out_data(out_data_f), .out_valid(out_valid_f), .out_ready(out_ready_f));
    msk_unmask_serial #(.d(3), .count(2)) u_g (
        .clk(clk), .rst(rst), .in_shares(shares_g), .in_valid(in_valid_g), .in_ready(in_ready_g),
        .out_data(out_data_g), .out_valid(out_valid_g), .out_ready(out_ready_g));

    // Advance to just after the next rising edge, where inputs are driven and outputs sampled.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
            $error("[TB] %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        shares_a = '0; shares_b = '0; shares_c = '0;
        shares_e = '0; shares_f = '0; shares_g = '0;
        #2;
        checkOutput("rst_in_ready", 32'(in_ready_a), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid_a), 32'd0);
        checkOutput("rst_out_data", 32'(out_data_b), 32'd0);
        applyStimulus();
        applyStimulus();
        rst = 1'b0;

        // d=2 count=1: share0=1 share1=0
        in_valid_a = 1'b1; shares_a = 2'b01;
        checkOutput("a_c0_in_ready", 32'(in_ready_a), 32'd1);
        applyStimulus();
        in_valid_a = 1'b0;
        checkOutput("a_c1_in_ready", 32'(in_ready_a), 32'd0);
        checkOutput("a_c1_out_valid", 32'(out_valid_a), 32'd0);
        checkOutput("a_c1_out_data", 32'(out_data_a), 32'd0);
        applyStimulus();
        checkOutput("a_c2_out_valid", 32'(out_valid_a), 32'd1);
        checkOutput("a_c2_out_data", 32'(out_data_a), 32'd1);
        applyStimulus();
        checkOutput("a_c3_in_ready", 32'(in_ready_a), 32'd1);
        checkOutput("a_c3_out_valid", 32'(out_valid_a), 32'd0);
        applyStimulus();
        checkOutput("a_c4_in_ready", 32'(in_ready_a), 32'd1);

        // d=3 count=4: bits (1,1,1) (0,1,1) (1,0,0) (0,0,1); garbage on inputs during ACC
        in_valid_b = 1'b1; shares_b = 12'h877;
        applyStimulus();
        shares_b = 12'hFFF;
        checkOutput("b_c1_out_valid", 32'(out_valid_b), 32'd0);
        applyStimulus();
        checkOutput("b_c2_out_valid", 32'(out_valid_b), 32'd0);
        applyStimulus();
        in_valid_b = 1'b0;
        checkOutput("b_c3_out_valid", 32'(out_valid_b), 32'd1);
        checkOutput("b_c3_out_data", 32'(out_data_b), 32'hD);
        applyStimulus();
        checkOutput("b_c4_in_ready", 32'(in_ready_b), 32'd1);
        checkOutput("b_c4_out_data", 32'(out_data_b), 32'd0);

        // d=2 count=2 with output backpressure: bit0 (1,0) bit1 (1,1)
        in_valid_c = 1'b1; shares_c = 4'b1101; out_ready_c = 1'b0;
        applyStimulus();
        in_valid_c = 1'b0;
        applyStimulus();
        in_valid_c = 1'b1; shares_c = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("c_hold%0d_out_valid", k), 32'(out_valid_c), 32'd1);
            checkOutput($sformatf("c_hold%0d_out_data", k), 32'(out_data_c), 32'd1);
            checkOutput($sformatf("c_hold%0d_in_ready", k), 32'(in_ready_c), 32'd0);
            if (k < 4) applyStimulus();
        end
        in_valid_c = 1'b0; out_ready_c = 1'b1;
        applyStimulus();
        checkOutput("c_release_in_ready", 32'(in_ready_c), 32'd1);
        checkOutput("c_release_out_valid", 32'(out_valid_c), 32'd0);
        checkOutput("c_release_out_data", 32'(out_data_c), 32'd0);

        // d=4 count=1: reset pulse in ACC at index 2 aborts the sharing
        in_valid_e = 1'b1; shares_e = 4'b0111;
        applyStimulus();
        in_valid_e = 1'b0;
        applyStimulus();
        rst = 1'b1;
        #1;
        checkOutput("e_rst_in_ready", 32'(in_ready_e), 32'd1);
        checkOutput("e_rst_out_valid", 32'(out_valid_e), 32'd0);
        checkOutput("e_rst_out_data", 32'(out_data_e), 32'd0);
        applyStimulus();
        rst = 1'b0;
        in_valid_e = 1'b1; shares_e = 4'b1110;
        checkOutput("e_post_out_valid", 32'(out_valid_e), 32'd0);
        checkOutput("e_post_in_ready", 32'(in_ready_e), 32'd1);
        applyStimulus();
        in_valid_e = 1'b0;
        for (int k = 1; k < 4; k++) begin
            checkOutput($sformatf("e_new_c%0d_out_valid", k), 32'(out_valid_e), 32'd0);
            applyStimulus();
        end
        checkOutput("e_new_c4_out_valid", 32'(out_valid_e), 32'd1);
        checkOutput("e_new_c4_out_data", 32'(out_data_e), 32'd1);
        applyStimulus();

        // d=1 count=8: result in the cycle after acceptance
        in_valid_f = 1'b1; shares_f = 8'hA5;
        applyStimulus();
        in_valid_f = 1'b0; shares_f = 8'h00;
        checkOutput("f_c1_out_valid", 32'(out_valid_f), 32'd1);
        checkOutput("f_c1_out_data", 32'(out_data_f), 32'hA5);
        applyStimulus();
        checkOutput("f_c2_in_ready", 32'(in_ready_f), 32'd1);

        // d=3 count=2: bit0 (1,0,1) bit1 (1,1,1); share register contents in DONE
        in_valid_g = 1'b1; shares_g = 6'h3D; out_ready_g = 1'b0;
        applyStimulus();
        in_valid_g = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("g_done_out_valid", 32'(out_valid_g), 32'd1);
        checkOutput("g_done_out_data", 32'(out_data_g), 32'd2);
        checkOutput("g_done_share_reg", 32'(u_g.share_reg), 32'(EXP_SHARE_REG_G));
        out_ready_g = 1'b1;
        applyStimulus();
        checkOutput("g_idle_in_ready", 32'(in_ready_g), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
